// File: rtl/match_sequencer.sv
// Match controller for a two-player ball game: serve delay, scoring, BCD match clock,
// pause and game-over handling. Every output is driven straight from a register.
`timescale 1ns/1ps
module match_sequencer #(
  parameter int SERVE_TICKS = 200,
  parameter int WIN_SCORE   = 7,
  parameter int MATCH_MIN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100hz,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       stop,
  output logic       serve,
  output logic       serve_dir,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic [3:0] t_min,
  output logic [3:0] t_s10,
  output logic [3:0] t_s1,
  output logic [2:0] state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    PAUSED     = 3'd3,
    OVER       = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);
  localparam logic [2:0] WIN        = 3'(WIN_SCORE);
  localparam logic [3:0] MIN_LOAD   = 4'(MATCH_MIN);

  state_t     state_reg, state_next;
  logic       stop_reg, stop_next;
  logic       serve_reg, serve_next;
  logic       serve_dir_reg, serve_dir_next;
  logic [2:0] score1_reg, score1_next;
  logic [2:0] score2_reg, score2_next;
  logic [3:0] t_min_reg, t_min_next;
  logic [3:0] t_s10_reg, t_s10_next;
  logic [3:0] t_s1_reg, t_s1_next;
  logic [1:0] winner_reg, winner_next;
  logic [7:0] serve_cnt_reg, serve_cnt_next;
  logic       start_r;
  logic       armed_reg;

  logic       start_edge;
  logic [3:0] dec_min, dec_s10, dec_s1;
  logic       dec_zero;

  // armed_reg masks the first clk after reset so a button held through reset is not an edge.
  assign start_edge = start & ~start_r & armed_reg;

  always_comb begin
    dec_min = t_min_reg;
    dec_s10 = t_s10_reg;
    dec_s1  = t_s1_reg;
    if (t_s1_reg != 4'd0) begin
      dec_s1 = t_s1_reg - 4'd1;
    end else if (t_s10_reg != 4'd0) begin
      dec_s10 = t_s10_reg - 4'd1;
      dec_s1  = 4'd9;
    end else if (t_min_reg != 4'd0) begin
      dec_min = t_min_reg - 4'd1;
      dec_s10 = 4'd5;
      dec_s1  = 4'd9;
    end
    dec_zero = (dec_min == 4'd0) && (dec_s10 == 4'd0) && (dec_s1 == 4'd0);
  end

  always_comb begin
    logic       win1, win2;
    logic [2:0] s1u, s2u;
    state_next     = state_reg;
    serve_next     = 1'b0;
    serve_dir_next = serve_dir_reg;
    score1_next    = score1_reg;
    score2_next    = score2_reg;
    t_min_next     = t_min_reg;
    t_s10_next     = t_s10_reg;
    t_s1_next      = t_s1_reg;
    winner_next    = winner_reg;
    serve_cnt_next = serve_cnt_reg;
    win1           = miss2 & ~miss1;
    win2           = miss1 & ~miss2;
    s1u            = score1_reg;
    s2u            = score2_reg;

    case (state_reg)
      IDLE: begin
        score1_next = 3'd0;
        score2_next = 3'd0;
        t_min_next  = MIN_LOAD;
        t_s10_next  = 4'd0;
        t_s1_next   = 4'd0;
        winner_next = 2'd0;
        if (start_edge) begin
          state_next     = SERVE_WAIT;
          serve_cnt_next = SERVE_LOAD;
        end
      end
      SERVE_WAIT: begin
        if (tick_100hz) begin
          serve_cnt_next = serve_cnt_reg - 8'd1;
          if (serve_cnt_reg == 8'd1) begin
            state_next = PLAY;
            serve_next = 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick_1hz) begin
          t_min_next = dec_min;
          t_s10_next = dec_s10;
          t_s1_next  = dec_s1;
        end
        if (win1 && score1_reg < WIN) s1u = score1_reg + 3'd1;
        if (win2 && score2_reg < WIN) s2u = score2_reg + 3'd1;
        score1_next = s1u;
        score2_next = s2u;
        // The serve goes toward whoever just missed.
        if (win1)      serve_dir_next = 1'b1;
        else if (win2) serve_dir_next = 1'b0;

        if (win1 && s1u == WIN) begin
          state_next  = OVER;
          winner_next = 2'd1;
        end else if (win2 && s2u == WIN) begin
          state_next  = OVER;
          winner_next = 2'd2;
        end else if (tick_1hz && dec_zero) begin
          state_next  = OVER;
          winner_next = (s1u > s2u) ? 2'd1 : (s2u > s1u) ? 2'd2 : 2'd3;
        end else if (miss1 || miss2) begin
          state_next     = SERVE_WAIT;
          serve_cnt_next = SERVE_LOAD;
        end else if (start_edge) begin
          state_next = PAUSED;
        end
      end
      PAUSED: begin
        if (start_edge) state_next = PLAY;
      end
      OVER: begin
        if (start_edge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    stop_next = (state_next != PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      stop_reg      <= 1'b1;
      serve_reg     <= 1'b0;
      serve_dir_reg <= 1'b0;
      score1_reg    <= 3'd0;
      score2_reg    <= 3'd0;
      t_min_reg     <= MIN_LOAD;
      t_s10_reg     <= 4'd0;
      t_s1_reg      <= 4'd0;
      winner_reg    <= 2'd0;
      serve_cnt_reg <= 8'd0;
      start_r       <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stop_reg      <= stop_next;
      serve_reg     <= serve_next;
      serve_dir_reg <= serve_dir_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      t_min_reg     <= t_min_next;
      t_s10_reg     <= t_s10_next;
      t_s1_reg      <= t_s1_next;
      winner_reg    <= winner_next;
      serve_cnt_reg <= serve_cnt_next;
      start_r       <= start;
      armed_reg     <= 1'b1;
    end
  end

  assign stop      = stop_reg;
  assign serve     = serve_reg;
  assign serve_dir = serve_dir_reg;
  assign score1    = score1_reg;
  assign score2    = score2_reg;
  assign t_min     = t_min_reg;
  assign t_s10     = t_s10_reg;
  assign t_s1      = t_s1_reg;
  assign state     = state_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: serve delay, scoring, pause, match clock,
// win by score and asynchronous reset, all against hand-computed values.
`timescale 1ns/1ps
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100hz = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic       miss1 = 1'b0;
  logic       miss2 = 1'b0;
  logic       stop, serve, serve_dir;
  logic [2:0] score1, score2, state;
  logic [3:0] t_min, t_s10, t_s1;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass = 0;
  int serve_pulses = 0;
  int pulses_before;

  match_sequencer dut (
    .clk(clk), .rst(rst), .tick_100hz(tick_100hz), .tick_1hz(tick_1hz),
    .start(start), .miss1(miss1), .miss2(miss2), .stop(stop), .serve(serve),
    .serve_dir(serve_dir), .score1(score1), .score2(score2), .t_min(t_min),
    .t_s10(t_s10), .t_s1(t_s1), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (serve) serve_pulses++;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0; step();
  endtask

  task automatic miss(input logic m1, input logic m2);
    miss1 = m1; miss2 = m2; step(); miss1 = 1'b0; miss2 = 1'b0;
  endtask

  task automatic tick100(input int n);
    repeat (n) begin
      tick_100hz = 1'b1; step(); tick_100hz = 1'b0; step();
    end
  endtask

  task automatic tick1();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic serve_ball(input string tag);
    tick100(200);
    check_eq(tag, int'(state), 2);
  endtask

  function automatic int timer_bcd();
    return int'({t_min, t_s10, t_s1});
  endfunction

  initial begin
    // Reset values
    step(); step();
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_stop", int'(stop), 1);
    check_eq("rst_serve", int'(serve), 0);
    check_eq("rst_scores", int'({score1, score2}), 0);
    check_eq("rst_timer", timer_bcd(), 'h300);
    check_eq("rst_winner", int'(winner), 0);
    rst = 1'b0;
    step(); step();

    // Serve timing: 200 ticks, serve on exactly one cycle
    pulse_start();
    check_eq("idle_to_wait", int'(state), 1);
    for (int i = 1; i <= 200; i++) begin
      tick_100hz = 1'b1; step(); tick_100hz = 1'b0;
      if (i == 199) begin
        check_eq("wait_199_state", int'(state), 1);
        check_eq("wait_199_serve", int'(serve), 0);
      end
      if (i == 200) begin
        check_eq("wait_200_state", int'(state), 2);
        check_eq("wait_200_serve", int'(serve), 1);
        check_eq("wait_200_stop", int'(stop), 0);
      end
      step();
    end
    check_eq("serve_cleared", int'(serve), 0);
    check_eq("serve_once", serve_pulses, 1);

    // Miss scoring
    miss(1'b1, 1'b0);
    check_eq("m1_score2", int'(score2), 1);
    check_eq("m1_dir", int'(serve_dir), 0);
    check_eq("m1_state", int'(state), 1);
    check_eq("m1_stop", int'(stop), 1);
    serve_ball("m1_serve");
    miss(1'b0, 1'b1);
    check_eq("m2_score1", int'(score1), 1);
    check_eq("m2_dir", int'(serve_dir), 1);
    serve_ball("m2_serve");
    miss(1'b1, 1'b1);
    check_eq("both_scores", int'({score1, score2}), 'o11);
    check_eq("both_dir", int'(serve_dir), 1);
    check_eq("both_state", int'(state), 1);
    serve_ball("both_serve");

    // Pause
    start = 1'b1; step(); start = 1'b0;
    check_eq("pause_state", int'(state), 3);
    check_eq("pause_stop", int'(stop), 1);
    step();
    tick1();
    miss(1'b1, 1'b0);
    check_eq("pause_timer", timer_bcd(), 'h300);
    check_eq("pause_scores", int'({score1, score2}), 'o11);
    pulse_start();
    check_eq("resume_state", int'(state), 2);

    // Bring scores to 2:2, then run the full match clock
    miss(1'b1, 1'b0);
    serve_ball("s22_a");
    miss(1'b0, 1'b1);
    serve_ball("s22_b");
    check_eq("s22_scores", int'({score1, score2}), 'o22);
    for (int i = 1; i <= 180; i++) begin
      tick1();
      if (i == 1)   check_eq("t_259", timer_bcd(), 'h259);
      if (i == 60)  check_eq("t_200", timer_bcd(), 'h200);
      if (i == 61)  check_eq("t_159", timer_bcd(), 'h159);
      if (i == 171) check_eq("t_009", timer_bcd(), 'h009);
      if (i == 179) begin
        check_eq("t_001", timer_bcd(), 'h001);
        check_eq("t_001_state", int'(state), 2);
      end
      if (i == 180) begin
        check_eq("t_000", timer_bcd(), 'h000);
        check_eq("tie_state", int'(state), 4);
        check_eq("tie_winner", int'(winner), 3);
        check_eq("tie_stop", int'(stop), 1);
      end
    end

    // OVER holds, then start returns to IDLE
    tick1();
    miss(1'b0, 1'b1);
    check_eq("over_hold_state", int'(state), 4);
    check_eq("over_hold_scores", int'({score1, score2}), 'o22);
    pulse_start();
    check_eq("over_to_idle", int'(state), 0);
    check_eq("idle_scores", int'({score1, score2}), 0);
    check_eq("idle_timer", timer_bcd(), 'h300);
    check_eq("idle_winner", int'(winner), 0);

    // Win by score
    pulse_start();
    serve_ball("win_serve0");
    repeat (6) begin
      miss(1'b0, 1'b1);
      serve_ball("win_serve");
    end
    check_eq("win_pre_score1", int'(score1), 6);
    pulses_before = serve_pulses;
    miss(1'b0, 1'b1);
    check_eq("win_score1", int'(score1), 7);
    check_eq("win_state", int'(state), 4);
    check_eq("win_winner", int'(winner), 1);
    step(); step(); step();
    check_eq("win_no_serve", serve_pulses, pulses_before);
    pulse_start();
    check_eq("win_to_idle", int'(state), 0);
    check_eq("win_cleared", int'({score1, score2}), 0);

    // Asynchronous reset in SERVE_WAIT with serve_cnt = 50
    pulse_start();
    serve_ball("rst_serve");
    miss(1'b0, 1'b1);
    tick100(150);
    check_eq("pre_rst_state", int'(state), 1);
    check_eq("pre_rst_score1", int'(score1), 1);
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    check_eq("arst_state", int'(state), 0);
    check_eq("arst_stop", int'(stop), 1);
    check_eq("arst_dir", int'(serve_dir), 0);
    check_eq("arst_score1", int'(score1), 0);
    check_eq("arst_timer", timer_bcd(), 'h300);
    step();
    rst = 1'b0;
    step(); step(); step();
    check_eq("held_start_no_edge", int'(state), 0);
    start = 1'b0;
    step();
    pulse_start();
    check_eq("post_rst_start", int'(state), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
